// File: rtl/spi_shift_engine_pkg.sv
// spi_shift_engine_pkg: shared types and defaults for the SPI shift engine.
// Holds the FSM state encoding and the default bus widths.
package spi_shift_engine_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_TURN  = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: request/response bus between controller and engine.
// master = controller side, slave = shift engine side.
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) ();

    logic [DATA_WIDTH-1:0] data_out;
    logic [CNT_WIDTH-1:0]  write_bits;
    logic [CNT_WIDTH-1:0]  read_bits;
    logic                  clk_inv;
    logic                  request_action;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;

    modport master (
        output data_out, write_bits, read_bits, clk_inv, request_action,
        input  busy, data_in, data_valid
    );

    modport slave (
        input  data_out, write_bits, read_bits, clk_inv, request_action,
        output busy, data_in, data_valid
    );

endinterface

// File: rtl/spi_shift_engine_bit_counter.sv
// spi_shift_engine_bit_counter: loadable bit down-counter plus sclk phase.
// Ports: clk, reset_n, load_i/count_i, en_i; ph_o phase, last_o final half-bit.
module spi_shift_engine_bit_counter #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    input  logic                 en_i,
    output logic                 ph_o,
    output logic                 last_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ph_q, ph_d;

    always_comb begin
        cnt_d = cnt_q;
        ph_d  = 1'b0;
        if (load_i) begin
            cnt_d = count_i;
        end else if (en_i) begin
            ph_d = ~ph_q;
            // a bit is consumed at the end of its high phase
            if (ph_q) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

    assign ph_o   = ph_q;
    assign last_o = en_i && ph_q && (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: 3-wire SPI serializer (setup, write, turn, read, done).
// Ports: clk, reset_n, bus (request/response), sclk, sdio (tri-state), csb.
module spi_shift_engine
    import spi_shift_engine_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int DESEL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_shift_engine_if.slave bus,
    output logic              sclk,
    inout  wire               sdio,
    output logic              csb
);

    localparam int SW = CNT_WIDTH + 1;
    localparam int YW = (DESEL_CYCLES > 2) ? $clog2(DESEL_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] DW_C = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [YW-1:0] DONE_LD = YW'(DESEL_CYCLES - 1);
    localparam logic [YW-1:0] TURN_LD = YW'(1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [CNT_WIDTH-1:0]  wb_q, wb_d;
    logic [CNT_WIDTH-1:0]  rb_q, rb_d;
    logic                  inv_q, inv_d;
    logic [YW-1:0]         cyc_q, cyc_d;

    logic [CNT_WIDTH-1:0]  w_cl, r_cl;
    logic [SW-1:0]         shamt;
    logic                  cnt_load;
    logic [CNT_WIDTH-1:0]  cnt_val;
    logic                  cnt_en;
    logic                  ph;
    logic                  last;
    logic                  oe;

    assign w_cl  = (bus.write_bits > DW_C) ? DW_C : bus.write_bits;
    assign r_cl  = (bus.read_bits > DW_C) ? DW_C : bus.read_bits;
    assign shamt = SW'(DATA_WIDTH) - {1'b0, w_cl};

    assign cnt_en = (state_q == ST_WRITE) || (state_q == ST_READ);

    spi_shift_engine_bit_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (cnt_load),
        .count_i (cnt_val),
        .en_i    (cnt_en),
        .ph_o    (ph),
        .last_o  (last)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cap_d    = cap_q;
        din_d    = din_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        inv_d    = inv_q;
        cyc_d    = cyc_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                // zero-length descriptors are dropped outright
                if (bus.request_action &&
                    ((w_cl != '0) || (r_cl != '0))) begin
                    state_d = ST_SETUP;
                    shift_d = bus.data_out << shamt;
                    cap_d   = '0;
                    wb_d    = w_cl;
                    rb_d    = r_cl;
                    inv_d   = bus.clk_inv;
                end
            end
            ST_SETUP: begin
                if (wb_q != '0) begin
                    state_d  = ST_WRITE;
                    cnt_load = 1'b1;
                    cnt_val  = wb_q;
                end else begin
                    state_d = ST_TURN;
                    cyc_d   = TURN_LD;
                end
            end
            ST_WRITE: begin
                if (ph) begin
                    shift_d = shift_q << 1;
                end
                if (last) begin
                    if (rb_q != '0) begin
                        state_d = ST_TURN;
                        cyc_d   = TURN_LD;
                    end else begin
                        state_d = ST_DONE;
                        cyc_d   = DONE_LD;
                    end
                end
            end
            ST_TURN: begin
                if (cyc_q == '0) begin
                    state_d  = ST_READ;
                    cnt_load = 1'b1;
                    cnt_val  = rb_q;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            ST_READ: begin
                if (ph) begin
                    cap_d = {cap_q[DATA_WIDTH-2:0], sdio};
                end
                // result lands in data_in for the first DONE cycle
                if (last) begin
                    state_d = ST_DONE;
                    din_d   = {cap_q[DATA_WIDTH-2:0], sdio};
                    cyc_d   = DONE_LD;
                end
            end
            ST_DONE: begin
                if (cyc_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cap_q   <= '0;
            din_q   <= '0;
            wb_q    <= '0;
            rb_q    <= '0;
            inv_q   <= 1'b1;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cap_q   <= cap_d;
            din_q   <= din_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            inv_q   <= inv_d;
            cyc_q   <= cyc_d;
        end
    end

    // only SETUP (with write bits) and WRITE ever drive the pin
    assign oe = ((state_q == ST_SETUP) && (wb_q != '0)) ||
                (state_q == ST_WRITE);
    assign sdio = oe ? shift_q[DATA_WIDTH-1] : 1'bz;

    assign sclk = inv_q ? ph : ~ph;
    assign csb  = (state_q == ST_IDLE) || (state_q == ST_DONE);

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.data_in    = din_q;
    assign bus.data_valid = (state_q == ST_DONE) && (cyc_q == DONE_LD);

endmodule
